chan_merge_rr: RTL
==================

Name: chan_merge_rr

Overview:
- Downstream stage of the per-channel pipeline array.
- Collects NUM_CHANNELS independent DATA_W-bit streams into one tagged output stream with valid/ready handshake.
- Each channel gets a small FIFO; the upstream pipeline cannot stall, so a full FIFO drops the incoming beat and flags it.
- A round-robin arbiter drains the FIFOs into a single registered output slot.

Parameters:
- NUM_CHANNELS, 4, number of input channels (≥2).
- DATA_W, 8, data width per channel.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2).
- DROP_CNT_W, 8, width of per-channel drop counters (optional feature only).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  [NUM_CHANNELS-1:0]  per-channel beat strobe.
- in_data  input  [DATA_W-1:0] x NUM_CHANNELS (unpacked)  per-channel data.
- out_valid  output  1  output slot holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  merged data.
- out_chan  output  CH_W = max(1,$clog2(NUM_CHANNELS))  source channel index.
- fifo_full  output  [NUM_CHANNELS-1:0]  per-channel FIFO full, registered.
- overflow  output  [NUM_CHANNELS-1:0]  one-cycle pulse, beat dropped.

Behaviour:
- Reset is synchronous and active-high on the single clock clk. While rst=1, every state element clears at the clock edge:
  - FIFO pointers and counts = 0; fifo_full = 0.
  - out_valid = 0, out_data = 0, out_chan = 0, overflow = 0.
  - Round-robin pointer = 0.
  - in_valid is ignored during reset.
- Reset mid-operation discards all queued and output beats. The first cycle after deassertion behaves like power-up.
- Push rules, per channel c:
  - in_valid[c] while count < FIFO_DEPTH writes in_data[c].
  - If count == FIFO_DEPTH and channel c is popped in the same cycle, the push is still accepted; count is unchanged.
  - If the FIFO is full with no same-cycle pop, the beat is dropped, the FIFO is unchanged, and overflow[c] = 1 in the next cycle only.
- Output slot is a two-state FSM, EMPTY / FULL:
  - EMPTY→FULL when any FIFO is non-empty.
  - FULL→EMPTY on out_ready with no pending FIFO.
  - FULL→FULL on out_ready with a pending FIFO (back-to-back reload).
  - While out_valid && !out_ready, out_data and out_chan hold stable and no pop occurs.
- Arbitration: grant when the slot is EMPTY or (FULL && out_ready).
  - Granted channel = first non-empty channel at or after rr_ptr, wrapping modulo NUM_CHANNELS.
  - On grant: pop that FIFO, load the slot, set rr_ptr = grant+1 (wrapping).
  - rr_ptr is unchanged when there is no grant.
- Latency: beat presented in cycle k → earliest out_valid in cycle k+2. Throughput is 1 beat/cycle with out_ready held high.
- FIFO order within a channel is strict FIFO. Read/write pointers wrap at FIFO_DEPTH; count has $clog2(FIFO_DEPTH)+1 bits.
- fifo_full reflects the post-edge count.

Optional Feature:
- Macro: CHAN_MERGE_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt, [DROP_CNT_W-1:0] x NUM_CHANNELS.
  - Each counter increments on every dropped beat of its channel and saturates at all-ones.
  - Counters clear on rst and on the new input drop_clr (1 bit, clears all; a clear wins over a simultaneous increment).
- When undefined: neither port exists, no counter logic; all other behaviour is identical.

Decomposition:
- Package chan_merge_pkg holds:
  - the output FSM state enum (ST_EMPTY, ST_FULL);
  - a helper function for the CH_W computation;
  - the default-parameter localparams.
- Sub-module chan_fifo: single-channel synchronous FIFO with push, pop, data, full, empty, and a push-when-full-with-pop bypass.
  - Instantiated in a labelled generate loop, one per channel.
- Arbiter and output slot stay in the top module.

Test Plan:
- Single beat: ch2 in_valid with 8'hA5, out_ready=1 → out_valid in cycle k+2 with out_data=A5, out_chan=2, for one cycle.
- Simultaneous beats: all 4 channels inject 10,11,12,13 in one cycle, rr_ptr=0 → outputs ch0..ch3 on consecutive cycles, data 10,11,12,13.
- Backpressure: out_ready=0 for 5 cycles while out_valid → out_data/out_chan stable; no FIFO pop; beats follow in order once out_ready=1.
- Overflow: out_ready=0, ch1 injects 6 beats 1..6 (FIFO_DEPTH=4, one beat in the slot) → overflow[1] pulses once for beat 6; after release, outputs are 1..5; drop_cnt[1]=1 when the macro is defined.
- Fairness: ch0 and ch3 inject continuously with out_ready=1 → output alternates 0,3,0,3 with no starvation.
- Reset mid-operation: assert rst with FIFOs half full and out_valid=1 → next cycle out_valid=0, fifo_full=0, and no stale beats after release.

Source files
------------

// File: rtl/chan_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chan_merge_pkg
// Brief    : Shared types, default parameters and helpers for chan_merge_rr.
// Revision : 1.0 - initial release
// ============================================================================
package chan_merge_pkg;

    localparam int c_def_num_channels = 4;
    localparam int c_def_data_w       = 8;
    localparam int c_def_fifo_depth   = 4;
    localparam int c_def_drop_cnt_w   = 8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

    function automatic int calc_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chan_merge_rr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chan_fifo
// Brief    : Single-channel synchronous FIFO; a push while full is still
//            accepted when the same cycle pops an entry.
// Revision : 1.0 - initial release
// ============================================================================
module chan_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;

    logic          w_at_cap;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [CW-1:0] w_count_nxt;

    assign w_at_cap  = (r_count == CW'(DEPTH));
    assign w_push_ok = push && (!w_at_cap || pop);
    assign w_pop_ok  = pop && (r_count != '0);
    assign dropped   = push && w_at_cap && !pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push_ok && w_pop_ok)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/chan_merge_rr.sv
`default_nettype none
// ============================================================================
// Module   : chan_merge_rr
// Brief    : Merges per-channel streams through per-channel FIFOs and a
//            round-robin arbiter into one registered, tagged output slot.
//            Optional per-channel drop counters: CHAN_MERGE_DROP_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module chan_merge_rr
    import chan_merge_pkg::*;
#(
    parameter int NUM_CHANNELS = c_def_num_channels,
    parameter int DATA_W       = c_def_data_w,
    parameter int FIFO_DEPTH   = c_def_fifo_depth,
`ifdef CHAN_MERGE_DROP_CNT_EN
    parameter int DROP_CNT_W   = c_def_drop_cnt_w,
`endif
    localparam int CH_W        = calc_ch_w(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef CHAN_MERGE_DROP_CNT_EN
    input  logic                    drop_clr,
    output logic [DROP_CNT_W-1:0]   drop_cnt [NUM_CHANNELS],
`endif
    input  logic [NUM_CHANNELS-1:0] in_valid,
    input  logic [DATA_W-1:0]       in_data [NUM_CHANNELS],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [CH_W-1:0]         out_chan,
    output logic [NUM_CHANNELS-1:0] fifo_full,
    output logic [NUM_CHANNELS-1:0] overflow
);
    slot_state_t       r_state;
    logic [CH_W-1:0]   r_rr_ptr;

    logic [DATA_W-1:0]       w_fifo_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_fifo_empty;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic [NUM_CHANNELS-1:0] w_drop;
    logic [CH_W-1:0]         w_scan_idx [NUM_CHANNELS];
    logic                    w_grant_en;
    logic                    w_grant_valid;
    logic [CH_W-1:0]         w_grant_idx;
    logic [CH_W-1:0]         w_rr_next;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (in_valid[c]),
            .push_data (in_data[c]),
            .pop       (w_pop[c]),
            .pop_data  (w_fifo_data[c]),
            .full      (fifo_full[c]),
            .empty     (w_fifo_empty[c]),
            .dropped   (w_drop[c])
        );
    end

    // Scan order starts at rr_ptr and wraps modulo NUM_CHANNELS.
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_scan
        assign w_scan_idx[i] = (int'(r_rr_ptr) + i >= NUM_CHANNELS)
                             ? CH_W'(int'(r_rr_ptr) + i - NUM_CHANNELS)
                             : CH_W'(int'(r_rr_ptr) + i);
    end

    assign w_grant_en = (r_state == ST_EMPTY) || out_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_grant_en && !w_grant_valid && !w_fifo_empty[w_scan_idx[i]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan_idx[i];
            end
        end
    end

    always_comb begin
        w_pop = '0;
        if (w_grant_valid) w_pop[w_grant_idx] = 1'b1;
    end

    assign w_rr_next = (w_grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_rr_ptr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            overflow  <= '0;
        end else begin
            overflow <= w_drop;
            if (w_grant_valid) begin
                r_state   <= ST_FULL;
                out_valid <= 1'b1;
                out_data  <= w_fifo_data[w_grant_idx];
                out_chan  <= w_grant_idx;
                r_rr_ptr  <= w_rr_next;
            end else if (r_state == ST_FULL && out_ready) begin
                r_state   <= ST_EMPTY;
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CHAN_MERGE_DROP_CNT_EN
    // Saturating counters; a clear takes priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rst || drop_clr)
                drop_cnt[c] <= '0;
            else if (w_drop[c] && (drop_cnt[c] != '1))
                drop_cnt[c] <= drop_cnt[c] + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
